// File: rtl/iod_delay_tap_ctrl.sv
// Per-lane IOD delay-line / eye-monitor sequencer: executes LOAD, MOVE and SAMPLE
// commands from the training engine and returns one response per command.
module iod_delay_tap_ctrl #(
  parameter int TAP_W      = 8,
  parameter int MAX_TAP    = 127,
  parameter int INIT_TAP   = 1,
  parameter int SETTLE_CYC = 4,
  parameter int SAMPLE_CYC = 16,
  parameter int CNT_W      = 5
) (
  input  logic             FAB_CLK,
  input  logic             ARST_N,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic             cmd_dir,
  input  logic [TAP_W-1:0] cmd_count,
  output logic             rsp_valid,
  output logic [TAP_W-1:0] rsp_tap,
  output logic [CNT_W-1:0] rsp_early_cnt,
  output logic [CNT_W-1:0] rsp_late_cnt,
  output logic             rsp_oor,
  output logic             rsp_err,
  output logic             DELAY_LINE_LOAD_0,
  output logic             DELAY_LINE_MOVE_0,
  output logic             DELAY_LINE_DIRECTION_0,
  input  logic             DELAY_LINE_OUT_OF_RANGE_0,
  output logic             EYE_MONITOR_CLEAR_FLAGS_0,
  input  logic             EYE_MONITOR_EARLY_0,
  input  logic             EYE_MONITOR_LATE_0
);

  localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int SMP_W = (SAMPLE_CYC > 1) ? $clog2(SAMPLE_CYC) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PULSE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_RESP
  } state_t;

  typedef enum logic [1:0] {
    OP_LOAD   = 2'b00,
    OP_MOVE   = 2'b01,
    OP_SAMPLE = 2'b10,
    OP_RSVD   = 2'b11
  } op_t;

  state_t           r_state;
  op_t              r_op;
  logic             r_dir;
  logic [TAP_W-1:0] r_rem;
  logic [TAP_W-1:0] r_tap;
  logic [SET_W-1:0] r_set_cnt;
  logic [SMP_W-1:0] r_smp_cnt;
  logic [CNT_W-1:0] r_early;
  logic [CNT_W-1:0] r_late;
  logic             r_ready;
  logic             r_rsp_valid;
  logic [TAP_W-1:0] r_rsp_tap;
  logic [CNT_W-1:0] r_rsp_early;
  logic [CNT_W-1:0] r_rsp_late;
  logic             r_rsp_oor;
  logic             r_rsp_err;
  logic             r_load;
  logic             r_move;
  logic             r_dir_out;
  logic             r_clear;

  logic             w_accept;
  logic             w_step_go;
  logic             w_step_dir;
  logic [TAP_W-1:0] w_step_rem;
  logic             w_at_limit;
  logic [CNT_W-1:0] w_early_nxt;
  logic [CNT_W-1:0] w_late_nxt;

  assign w_accept = (r_state == ST_IDLE) && cmd_valid && r_ready;

  // A MOVE step is evaluated either straight from the accepted command or at the
  // end of each settle gap; both paths share one limit check before pulsing.
  assign w_step_go  = (w_accept && (op_t'(cmd_op) == OP_MOVE)) ||
                      ((r_state == ST_SETTLE) && (r_set_cnt == '0) && (r_op == OP_MOVE));
  assign w_step_dir = (r_state == ST_IDLE) ? cmd_dir : r_dir;
  assign w_step_rem = (r_state == ST_IDLE) ? cmd_count : r_rem;
  assign w_at_limit = w_step_dir ? (r_tap == TAP_W'(MAX_TAP)) : (r_tap == '0);

  assign w_early_nxt = (EYE_MONITOR_EARLY_0 && (r_early != '1)) ? r_early + CNT_W'(1) : r_early;
  assign w_late_nxt  = (EYE_MONITOR_LATE_0  && (r_late  != '1)) ? r_late  + CNT_W'(1) : r_late;

  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      r_state     <= ST_IDLE;
      r_op        <= OP_LOAD;
      r_dir       <= 1'b0;
      r_rem       <= '0;
      r_tap       <= TAP_W'(INIT_TAP);
      r_set_cnt   <= '0;
      r_smp_cnt   <= '0;
      r_early     <= '0;
      r_late      <= '0;
      r_ready     <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_tap   <= TAP_W'(INIT_TAP);
      r_rsp_early <= '0;
      r_rsp_late  <= '0;
      r_rsp_oor   <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_load      <= 1'b0;
      r_move      <= 1'b0;
      r_dir_out   <= 1'b0;
      r_clear     <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_ready <= 1'b0;
            r_op    <= op_t'(cmd_op);
            r_dir   <= cmd_dir;
            unique case (op_t'(cmd_op))
              OP_LOAD: begin
                r_load  <= 1'b1;
                r_tap   <= TAP_W'(INIT_TAP);
                r_state <= ST_PULSE;
              end
              OP_SAMPLE: begin
                r_clear <= 1'b1;
                r_early <= '0;
                r_late  <= '0;
                r_state <= ST_PULSE;
              end
              OP_RSVD: begin
                r_rsp_valid <= 1'b1;
                r_rsp_err   <= 1'b1;
                r_rsp_tap   <= r_tap;
                r_state     <= ST_RESP;
              end
              OP_MOVE: ;
            endcase
          end
        end
        ST_PULSE: begin
          r_load    <= 1'b0;
          r_move    <= 1'b0;
          r_clear   <= 1'b0;
          r_set_cnt <= SET_W'(SETTLE_CYC - 1);
          r_state   <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (r_set_cnt != '0) begin
            r_set_cnt <= r_set_cnt - SET_W'(1);
          end else if (r_op == OP_SAMPLE) begin
            r_smp_cnt <= SMP_W'(SAMPLE_CYC - 1);
            r_state   <= ST_SAMPLE;
          end else if (r_op != OP_MOVE) begin
            r_rsp_valid <= 1'b1;
            r_rsp_tap   <= r_tap;
            r_state     <= ST_RESP;
          end
        end
        ST_SAMPLE: begin
          r_early <= w_early_nxt;
          r_late  <= w_late_nxt;
          if (r_smp_cnt == '0) begin
            r_rsp_early <= w_early_nxt;
            r_rsp_late  <= w_late_nxt;
            r_rsp_valid <= 1'b1;
            r_rsp_tap   <= r_tap;
            r_state     <= ST_RESP;
          end else begin
            r_smp_cnt <= r_smp_cnt - SMP_W'(1);
          end
        end
        ST_RESP: begin
          r_rsp_valid <= 1'b0;
          r_rsp_oor   <= 1'b0;
          r_rsp_err   <= 1'b0;
          r_dir_out   <= 1'b0;
          r_ready     <= 1'b1;
          r_state     <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_step_go) begin
        r_dir_out <= w_step_dir;
        if (w_step_rem == '0) begin
          r_rsp_valid <= 1'b1;
          r_rsp_tap   <= r_tap;
          r_state     <= ST_RESP;
        end else if (w_at_limit || DELAY_LINE_OUT_OF_RANGE_0) begin
          r_rsp_valid <= 1'b1;
          r_rsp_oor   <= 1'b1;
          r_rsp_tap   <= r_tap;
          r_state     <= ST_RESP;
        end else begin
          r_move  <= 1'b1;
          r_tap   <= w_step_dir ? r_tap + TAP_W'(1) : r_tap - TAP_W'(1);
          r_rem   <= w_step_rem - TAP_W'(1);
          r_state <= ST_PULSE;
        end
      end
    end
  end

  assign cmd_ready                 = r_ready;
  assign rsp_valid                 = r_rsp_valid;
  assign rsp_tap                   = r_rsp_tap;
  assign rsp_early_cnt             = r_rsp_early;
  assign rsp_late_cnt              = r_rsp_late;
  assign rsp_oor                   = r_rsp_oor;
  assign rsp_err                   = r_rsp_err;
  assign DELAY_LINE_LOAD_0         = r_load;
  assign DELAY_LINE_MOVE_0         = r_move;
  assign DELAY_LINE_DIRECTION_0    = r_dir_out;
  assign EYE_MONITOR_CLEAR_FLAGS_0 = r_clear;

endmodule

// File: tb/tb_iod_delay_tap_ctrl.sv
// Scoreboard bench for iod_delay_tap_ctrl: stimulus pushes model responses into a
// queue, a negedge monitor pops and compares on rsp_valid and watches the IOD pulses.
module tb_iod_delay_tap_ctrl;

  localparam int S    = 4;
  localparam int SMP  = 16;
  localparam int MAXT = 127;
  localparam int INIT = 1;
  localparam int NO   = 1000;

  logic       FAB_CLK = 1'b0;
  logic       ARST_N;
  logic       cmd_valid, cmd_dir;
  logic [1:0] cmd_op;
  logic [7:0] cmd_count;
  logic       OOR, EARLY, LATE;

  logic       cmd_ready, rsp_valid, rsp_oor, rsp_err;
  logic [7:0] rsp_tap;
  logic [4:0] rsp_early, rsp_late;
  logic       LOAD, MOVE, DIR, CLEAR;

  logic       s_ready, s_valid, s_oor, s_err, s_load, s_move, s_dir, s_clear;
  logic [7:0] s_tap;
  logic [2:0] s_early, s_late;

  iod_delay_tap_ctrl u_dut (
    .FAB_CLK(FAB_CLK), .ARST_N(ARST_N), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_dir(cmd_dir), .cmd_count(cmd_count), .rsp_valid(rsp_valid),
    .rsp_tap(rsp_tap), .rsp_early_cnt(rsp_early), .rsp_late_cnt(rsp_late),
    .rsp_oor(rsp_oor), .rsp_err(rsp_err), .DELAY_LINE_LOAD_0(LOAD),
    .DELAY_LINE_MOVE_0(MOVE), .DELAY_LINE_DIRECTION_0(DIR),
    .DELAY_LINE_OUT_OF_RANGE_0(OOR), .EYE_MONITOR_CLEAR_FLAGS_0(CLEAR),
    .EYE_MONITOR_EARLY_0(EARLY), .EYE_MONITOR_LATE_0(LATE)
  );

  iod_delay_tap_ctrl #(.CNT_W(3)) u_sat (
    .FAB_CLK(FAB_CLK), .ARST_N(ARST_N), .cmd_valid(cmd_valid), .cmd_ready(s_ready),
    .cmd_op(cmd_op), .cmd_dir(cmd_dir), .cmd_count(cmd_count), .rsp_valid(s_valid),
    .rsp_tap(s_tap), .rsp_early_cnt(s_early), .rsp_late_cnt(s_late),
    .rsp_oor(s_oor), .rsp_err(s_err), .DELAY_LINE_LOAD_0(s_load),
    .DELAY_LINE_MOVE_0(s_move), .DELAY_LINE_DIRECTION_0(s_dir),
    .DELAY_LINE_OUT_OF_RANGE_0(OOR), .EYE_MONITOR_CLEAR_FLAGS_0(s_clear),
    .EYE_MONITOR_EARLY_0(EARLY), .EYE_MONITOR_LATE_0(LATE)
  );

  always #5 FAB_CLK = ~FAB_CLK;

  int cyc = 0;
  always @(posedge FAB_CLK) cyc <= cyc + 1;

  typedef struct {
    int n; int lat; int op; int dir; int tap; int early; int late;
    int oor; int err; int nload; int nmove; int nclr;
  } exp_t;

  exp_t q[$];
  int total = 0, bad = 0, rsp_cnt = 0, viol = 0;
  int m_tap = INIT, m_early = 0, m_late = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Reference: tap walk, abort rule and eye window computed directly from the command rules.
  task automatic model(input int op, input int dir, input int count, input logic [31:0] ep,
                       input logic [31:0] lp, input int oor_from, output exp_t e);
    int k, ce, cl;
    e = '{default: 0};
    e.op = op; e.dir = dir;
    case (op)
      0: begin m_tap = INIT; e.lat = 2 + S; e.nload = 1; end
      1: begin
        k = 0;
        for (int j = 0; j < count; j++) begin
          if ((dir != 0 && m_tap == MAXT) || (dir == 0 && m_tap == 0) || (j * (1 + S) >= oor_from)) begin
            e.oor = 1;
            break;
          end
          m_tap = m_tap + ((dir != 0) ? 1 : -1);
          k++;
        end
        e.lat = 1 + k * (1 + S);
        e.nmove = k;
      end
      2: begin
        ce = 0; cl = 0;
        for (int r = 2 + S; r <= 1 + S + SMP; r++) begin
          ce += int'(ep[r]);
          cl += int'(lp[r]);
        end
        m_early = min_i(ce, 31);
        m_late  = min_i(cl, 31);
        e.lat = 2 + S + SMP;
        e.nclr = 1;
      end
      default: begin e.err = 1; e.lat = 1; end
    endcase
    e.tap = m_tap; e.early = m_early; e.late = m_late;
  endtask

  // Called at posedge+1; returns at posedge+1 after the response has been observed.
  task automatic issue(input int op, input int dir, input int count, input logic [31:0] ep,
                       input logic [31:0] lp, input int oor_from);
    exp_t e;
    int waited, start, r;
    waited = 0;
    while (!cmd_ready && waited < 2000) begin @(posedge FAB_CLK); #1; waited++; end
    if (!cmd_ready) begin chk("ready_timeout", 0, 1); return; end
    cmd_valid = 1'b1; cmd_op = 2'(op); cmd_dir = 1'(dir); cmd_count = 8'(count);
    EARLY = ep[0]; LATE = lp[0]; OOR = (oor_from <= 0);
    model(op, dir, count, ep, lp, oor_from, e);
    e.n = cyc;
    q.push_back(e);
    start = rsp_cnt;
    r = 0;
    while (rsp_cnt == start && r < 2000) begin
      @(posedge FAB_CLK); #1;
      r++;
      cmd_valid = 1'b0;
      EARLY = (r < 32) ? ep[r] : 1'b0;
      LATE  = (r < 32) ? lp[r] : 1'b0;
      OOR   = (r >= oor_from);
    end
    if (rsp_cnt == start) chk("rsp_timeout", 0, 1);
    EARLY = 1'b0; LATE = 1'b0; OOR = 1'b0;
  endtask

  // Monitor: protocol watch every cycle, scoreboard compare on each response.
  int   busy = 0, nl = 0, nm = 0, nc = 0, exp_dir = 0;
  exp_t me;
  initial begin
    forever begin
      @(negedge FAB_CLK);
      if (!ARST_N) begin
        busy = 0; nl = 0; nm = 0; nc = 0;
      end else begin
        if (int'(LOAD) + int'(MOVE) + int'(CLEAR) > 1) viol++;
        if ((LOAD || MOVE || CLEAR) && busy == 0) viol++;
        if (!rsp_valid && (rsp_oor || rsp_err)) viol++;
        if (s_valid != rsp_valid) viol++;
        if (busy != 0) begin
          nl += int'(LOAD); nm += int'(MOVE); nc += int'(CLEAR);
          if (cmd_ready) viol++;
          if (q.size() > 0) begin
            exp_dir = (q[0].op == 1) ? q[0].dir : 0;
            if (int'(DIR) != exp_dir) viol++;
          end
        end else if (DIR) viol++;
        if (rsp_valid) begin
          rsp_cnt++;
          if (q.size() == 0) chk("unexpected_rsp", 1, 0);
          else begin
            me = q.pop_front();
            chk("latency", cyc - me.n, me.lat);
            chk("rsp_tap", int'(rsp_tap), me.tap);
            chk("rsp_early", int'(rsp_early), me.early);
            chk("rsp_late", int'(rsp_late), me.late);
            chk("sat_early", int'(s_early), min_i(me.early, 7));
            chk("sat_late", int'(s_late), min_i(me.late, 7));
            chk("rsp_oor", int'(rsp_oor), me.oor);
            chk("rsp_err", int'(rsp_err), me.err);
            chk("load_pulses", nl, me.nload);
            chk("move_pulses", nm, me.nmove);
            chk("clear_pulses", nc, me.nclr);
            chk("protocol", viol, 0);
            viol = 0;
          end
          busy = 0; nl = 0; nm = 0; nc = 0;
        end else if (cmd_valid && cmd_ready) begin
          busy = 1; nl = 0; nm = 0; nc = 0;
        end
      end
    end
  end

  int n_rst;
  initial begin
    ARST_N = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_dir = 1'b0; cmd_count = '0;
    OOR = 1'b0; EARLY = 1'b0; LATE = 1'b0;
    repeat (2) @(negedge FAB_CLK);
    chk("reset_ready", int'(cmd_ready), 1);
    chk("reset_tap", int'(rsp_tap), INIT);
    chk("reset_outputs", int'({rsp_valid, rsp_oor, rsp_err, LOAD, MOVE, DIR, CLEAR}), 0);
    chk("reset_counts", int'({rsp_early, rsp_late}), 0);
    ARST_N = 1'b1;
    @(posedge FAB_CLK); #1;

    issue(0, 0, 0, '0, '0, NO);
    issue(1, 1, 3, '0, '0, NO);
    issue(0, 0, 0, '0, '0, NO);
    issue(1, 1, 1, '0, '0, NO);
    issue(1, 0, 5, '0, '0, NO);
    issue(0, 0, 0, '0, '0, NO);
    issue(1, 1, 125, '0, '0, NO);
    issue(1, 1, 3, '0, '0, NO);
    issue(0, 0, 0, '0, '0, NO);
    issue(1, 1, 4, '0, '0, 8);
    issue(2, 0, 0, 32'h0000_FFC0, 32'h0000_1C00, NO);
    issue(2, 0, 0, 32'hFFFF_FFFF, 32'h0000_0000, NO);
    issue(3, 1, 7, '0, '0, NO);
    issue(1, 0, 0, '0, '0, NO);

    // Reset during the second MOVE step: pulse must vanish and no response appear.
    issue(0, 0, 0, '0, '0, NO);
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_dir = 1'b1; cmd_count = 8'd3;
    n_rst = cyc;
    @(posedge FAB_CLK); #1;
    cmd_valid = 1'b0;
    repeat (5) @(posedge FAB_CLK);
    #1;
    chk("rst_move_cycle", cyc - n_rst, 6);
    chk("rst_move_before", int'(MOVE), 1);
    ARST_N = 1'b0;
    #1;
    chk("rst_move_dropped", int'(MOVE), 0);
    chk("rst_dir_dropped", int'(DIR), 0);
    chk("rst_rsp_quiet", int'({rsp_valid, rsp_oor, rsp_err}), 0);
    repeat (2) @(negedge FAB_CLK);
    ARST_N = 1'b1;
    m_tap = INIT; m_early = 0; m_late = 0;
    repeat (20) @(posedge FAB_CLK);
    #1;
    chk("rst_ready_after", int'(cmd_ready), 1);
    chk("rst_tap_after", int'(rsp_tap), INIT);
    issue(1, 1, 0, '0, '0, NO);

    for (int i = 0; i < 40; i++) begin
      int op, sel;
      sel = int'($urandom_range(0, 9));
      op = (sel == 0) ? 0 : (sel <= 5) ? 1 : (sel <= 8) ? 2 : 3;
      issue(op, int'($urandom_range(0, 1)), int'($urandom_range(0, 8)), $urandom, $urandom,
            ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 30)) : NO);
    end

    repeat (5) @(posedge FAB_CLK);
    #1;
    chk("final_protocol", viol, 0);
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/iod_delay_tap_ctrl.md
Name: iod_delay_tap_ctrl

Overview:
- Per-lane sequencer that drives the dynamic delay-line and eye-monitor controls of one DDR4 PHY IOD lane (address/command or DQ bit).
- Runs in the FAB_CLK domain directly upstream of the IOD.
- Accepts load/move/sample commands from the training engine over a valid/ready handshake.
- Issues single-cycle delay-line pulses with settle gaps and tracks the absolute tap position.
- Accumulates eye-monitor early/late hits over a fixed window and returns one response per command.

Parameters:
- TAP_W, 8, width of tap position and move count.
- MAX_TAP, 127, highest legal tap index.
- INIT_TAP, 1, tap index after a LOAD; matches the IOD static delay value.
- SETTLE_CYC, 4, idle cycles after each LOAD/MOVE/CLEAR pulse (≥1).
- SAMPLE_CYC, 16, eye-monitor observation window in cycles (≥1).
- CNT_W, 5, width of the early/late hit counters.

Ports:
- FAB_CLK  in  1  fabric clock, shared with the IOD RX_CLK/TX_CLK.
- ARST_N  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  2  00 LOAD, 01 MOVE, 10 SAMPLE, 11 reserved.
- cmd_dir  in  1  MOVE direction; 1 = increment tap.
- cmd_count  in  TAP_W  MOVE step count.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_tap  out  TAP_W  tap position at response.
- rsp_early_cnt  out  CNT_W  early hits in the last SAMPLE.
- rsp_late_cnt  out  CNT_W  late hits in the last SAMPLE.
- rsp_oor  out  1  MOVE aborted on a range limit.
- rsp_err  out  1  reserved op received.
- DELAY_LINE_LOAD_0  out  1  to IOD.
- DELAY_LINE_MOVE_0  out  1  to IOD.
- DELAY_LINE_DIRECTION_0  out  1  to IOD.
- DELAY_LINE_OUT_OF_RANGE_0  in  1  from IOD.
- EYE_MONITOR_CLEAR_FLAGS_0  out  1  to IOD.
- EYE_MONITOR_EARLY_0  in  1  from IOD.
- EYE_MONITOR_LATE_0  in  1  from IOD.

Behaviour:
- Reset (async assert, sync release):
  - State IDLE; tap = INIT_TAP.
  - All outputs 0 except cmd_ready = 1 and rsp_tap = INIT_TAP.
  - Reset mid-operation drops MOVE/LOAD/CLEAR in the same instant; no response is issued.
- Accept:
  - A command is accepted on the cycle with cmd_valid && cmd_ready (cycle N).
  - op, dir and count are captured. cmd_ready = 0 from N+1 until the cycle after rsp_valid.
- States: IDLE, PULSE, SETTLE, SAMPLE, RESP.
- LOAD:
  - DELAY_LINE_LOAD_0 = 1 in N+1; tap <= INIT_TAP.
  - SETTLE for SETTLE_CYC cycles, then RESP.
  - rsp_valid at N+2+SETTLE_CYC (default N+6).
- MOVE:
  - DELAY_LINE_DIRECTION_0 = cmd_dir from N+1 and held until RESP ends; it returns to 0 in IDLE.
  - count = 0: RESP in N+1, no pulse.
  - Each step:
    - Check before pulsing. If dir = 1 and tap == MAX_TAP, or dir = 0 and tap == 0, or DELAY_LINE_OUT_OF_RANGE_0 = 1: go to RESP with rsp_oor = 1 and issue no pulse.
    - Otherwise MOVE = 1 for one cycle, tap ±1, remaining −1, then SETTLE_CYC cycles.
  - Step period is 1+SETTLE_CYC. rsp_valid at N+1+k·(1+SETTLE_CYC) for k steps completed without abort.
- SAMPLE:
  - EYE_MONITOR_CLEAR_FLAGS_0 = 1 in N+1, then SETTLE_CYC cycles.
  - Then SAMPLE_CYC cycles, each incrementing early_cnt/late_cnt when the corresponding input is 1.
  - Counters saturate at 2^CNT_W−1. Both counters clear at the CLEAR pulse.
  - rsp_valid at N+2+SETTLE_CYC+SAMPLE_CYC.
- Reserved op: rsp_valid in N+1 with rsp_err = 1; tap unchanged.
- RESP:
  - rsp_valid = 1 for exactly one cycle, then IDLE.
  - rsp_tap, rsp_early_cnt and rsp_late_cnt hold their values until the next RESP.
  - rsp_oor and rsp_err are valid only with rsp_valid and are 0 otherwise.
- Output timing:
  - LOAD, MOVE and CLEAR are never high simultaneously. Each is high for at most one cycle per pulse.
  - All IOD-facing outputs are registered.
- Tap arithmetic: unsigned TAP_W; never wraps, because the limits are checked before pulsing.

Test Plan:
- Reset then LOAD → LOAD pulse at N+1; rsp_valid at N+6; rsp_tap = 1; rsp_oor = 0; cmd_ready low N+1..N+6.
- MOVE dir = 1, count = 3 from tap 1 → 3 MOVE pulses at N+1, N+6, N+11; DIRECTION = 1 throughout; rsp_valid at N+16; rsp_tap = 4.
- MOVE dir = 0, count = 5 from tap 2 → 2 pulses, then abort; rsp_tap = 0; rsp_oor = 1. Same test with dir = 1 from tap 126, count = 3 → rsp_tap = 127, rsp_oor = 1.
- Force DELAY_LINE_OUT_OF_RANGE_0 = 1 during the 2nd settle of MOVE count = 4 → exactly 2 pulses; rsp_oor = 1.
- SAMPLE with EARLY high for 10 cycles and LATE for 3 inside the window → CLEAR at N+1; rsp_valid at N+22; early = 10, late = 3. Hold EARLY high for all 16 with CNT_W = 3 → early = 7.
- Assert ARST_N low during the 2nd step of a MOVE → MOVE drops immediately; no rsp_valid; after release tap = 1 and cmd_ready = 1. Reserved op 11 → rsp_err = 1 at N+1.
